// File: rtl/multicycle_alu.sv
// Multi-cycle RV32 ALU: single-cycle integer/compare ops plus iterative
// shift-add multiply and restoring divide behind a start/done handshake.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_PASSB = 5'd5, OP_SLT = 5'd6, OP_SGE = 5'd7;
    localparam logic [4:0] OP_SLTU = 5'd8, OP_SGEU = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHU = 5'd12, OP_DIV = 5'd13, OP_DIVU = 5'd14;
    localparam logic [4:0] OP_REM = 5'd15, OP_REMU = 5'd16;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [4:0]         op_q;
    logic               a_sgn_q, b_sgn_q;
    logic [WIDTH-1:0]   m_q;
    logic [2*WIDTH-1:0] acc, acc_nx, prod;

    logic               iter_op, signed_in, div_zero, ovf, single;
    logic               lt_s, lt_u, accept, res_we, flag_d, is_mul, last;
    logic [WIDTH-1:0]   fast_res, iter_res, res_d, mag_a, mag_b;
    logic [WIDTH:0]     add_sum, shifted;
    logic               ge;

    assign iter_op   = (op >= OP_MUL) && (op <= OP_REMU);
    assign signed_in = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign div_zero  = (op >= OP_DIV) && (op <= OP_REMU) && (b == '0);
    assign ovf       = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_VAL) && (b == '1);
    assign single    = !iter_op || div_zero || ovf;
    assign lt_s      = $signed(a) < $signed(b);
    assign lt_u      = a < b;
    assign mag_a     = (signed_in && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (signed_in && b[WIDTH-1]) ? -b : b;

    always_comb begin
        fast_res = b;
        flag_d   = 1'b0;
        case (op)
            OP_ADD:   fast_res = a + b;
            OP_SUB:   fast_res = a - b;
            OP_AND:   fast_res = a & b;
            OP_OR:    fast_res = a | b;
            OP_XOR:   begin fast_res = a ^ b; flag_d = (a == b); end
            OP_PASSB: begin fast_res = b;     flag_d = (a != b); end
            OP_SLT:   begin fast_res = {{(WIDTH-1){1'b0}}, lt_s};  flag_d = lt_s;  end
            OP_SGE:   begin fast_res = {{(WIDTH-1){1'b0}}, !lt_s}; flag_d = !lt_s; end
            OP_SLTU:  begin fast_res = {{(WIDTH-1){1'b0}}, lt_u};  flag_d = lt_u;  end
            OP_SGEU:  begin fast_res = {{(WIDTH-1){1'b0}}, !lt_u}; flag_d = !lt_u; end
            OP_DIV:   fast_res = div_zero ? '1 : MIN_VAL;
            OP_DIVU:  fast_res = '1;
            OP_REM:   fast_res = div_zero ? a : '0;
            OP_REMU:  fast_res = a;
            default:  fast_res = b;
        endcase
    end

    // acc holds {partial product} for multiply and {remainder, dividend/quotient} for divide
    assign is_mul  = op_q <= OP_MULHU;
    assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_q} : '0);
    assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign ge      = shifted >= {1'b0, m_q};

    always_comb begin
        acc_nx = {add_sum, acc[WIDTH-1:1]};
        if (!is_mul) begin
            acc_nx = {(ge ? shifted[WIDTH-1:0] - m_q : shifted[WIDTH-1:0]), acc[WIDTH-2:0], ge};
        end
    end

    always_comb begin
        prod     = (a_sgn_q ^ b_sgn_q) ? -acc_nx : acc_nx;
        iter_res = '0;
        case (op_q)
            OP_MUL:            iter_res = acc_nx[WIDTH-1:0];
            OP_MULH, OP_MULHU: iter_res = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:   iter_res = (a_sgn_q ^ b_sgn_q) ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
            OP_REM, OP_REMU:   iter_res = a_sgn_q ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH];
            default:           iter_res = '0;
        endcase
    end

    assign last = cnt == CW'(WIDTH - 1);
    assign busy = state == RUN;
    assign done = state == DONE;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        res_we   = 1'b0;
        res_d    = fast_res;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = single ? DONE : RUN;
                    res_we   = single;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                    res_we   = 1'b1;
                    res_d    = iter_res;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_q    <= '0;
            a_sgn_q <= 1'b0;
            b_sgn_q <= 1'b0;
            m_q     <= '0;
            acc     <= '0;
            result  <= '0;
            flag    <= 1'b0;
        end else begin
            if (accept && !single) begin
                cnt     <= '0;
                op_q    <= op;
                a_sgn_q <= signed_in && a[WIDTH-1];
                b_sgn_q <= signed_in && b[WIDTH-1];
                m_q     <= mag_b;
                acc     <= {{WIDTH{1'b0}}, mag_a};
            end else if (state == RUN) begin
                acc <= acc_nx;
                cnt <= cnt + CW'(1);
            end
            if (res_we) begin
                result <= res_d;
                flag   <= (state == RUN) ? 1'b0 : flag_d;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: expectations queued at issue, popped at done.
module tb_multicycle_alu;
    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, flag;
    logic [4:0]  op;
    logic [31:0] a, b, result;
    logic        start8, busy8, done8, flag8;
    logic [4:0]  op8;
    logic [7:0]  a8, b8, result8;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flag(flag)
    );

    multicycle_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .flag(flag8)
    );

    typedef struct {
        logic [31:0] res;
        logic        flg;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic ef, input int el);
        sb.push_back('{er, ef, el, tag});
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (el > 1) check({tag, " busy"}, busy, 1);
    endtask

    task automatic collect(input int lat0);
        int   lat = lat0;
        exp_t e;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        check({e.tag, " done"}, done, 1);
        check({e.tag, " busy_at_done"}, busy, 0);
        check({e.tag, " result"}, result, e.res);
        check({e.tag, " flag"}, flag, e.flg);
        check({e.tag, " latency"}, lat, e.lat);
    endtask

    task automatic issue(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic ef, input int el);
        drive(tag, o, x, y, er, ef, el);
        collect(1);
    endtask

    task automatic issue8(input string tag, input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] er, input int el);
        int lat = 1;
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " done"}, done8, 1);
        check({tag, " result"}, result8, er);
        check({tag, " latency"}, lat, el);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic seen_done;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset flag", flag, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue("add_pre", 5'd0, 32'd10, 32'd20, 32'd30, 1'b0, 1);

        // abort a multiply with reset at cycle 5
        op = 5'd10; a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_mul busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort result", result, 0);
        check("abort flag", flag, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen_done = seen_done | done;
        end
        check("abort no_done", seen_done, 0);
        issue("add_after_reset", 5'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1);

        issue("sub", 5'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
        issue("slt", 5'd6, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1);
        issue("sltu", 5'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        issue("xor_eq", 5'd4, 32'h1234, 32'h1234, 32'd0, 1'b1, 1);
        issue("and", 5'd2, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1);
        issue("or", 5'd3, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1);
        issue("passb", 5'd5, 32'd3, 32'd4, 32'd4, 1'b1, 1);
        issue("sge", 5'd7, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1);
        issue("sgeu", 5'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        issue("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1);
        issue("op20", 5'd20, 32'd1, 32'hABCD, 32'hABCD, 1'b0, 1);

        issue("mul", 5'd10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33);
        issue("mulh", 5'd11, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
        issue("mulhu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        issue("div", 5'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        issue("rem", 5'd15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        issue("divu", 5'd14, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        issue("remu", 5'd16, 32'd100, 32'd7, 32'd2, 1'b0, 33);

        issue("div0", 5'd13, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        issue("rem0", 5'd15, 32'd5, 32'd0, 32'd5, 1'b0, 1);
        issue("divu0", 5'd14, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        issue("remu0", 5'd16, 32'd5, 32'd0, 32'd5, 1'b0, 1);
        issue("div_ovf", 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        issue("rem_ovf", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);

        // start during RUN is ignored and operand changes do not leak in
        drive("mul_hs", 5'd10, 32'd7, 32'd9, 32'd63, 1'b0, 33);
        repeat (5) begin
            @(posedge clk); #1;
        end
        op = 5'd0; a = 32'd100; b = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'd55;
        check("hs still_busy", busy, 1);
        collect(7);
        @(posedge clk); #1;
        check("hs no_extra_done", done, 0);

        for (int i = 1; i <= 3; i++) begin
            op = 5'd0; a = 32'(i); b = 32'(10 * i); start = 1'b1;
            sb.push_back('{32'(11 * i), 1'b0, 1, "b2b"});
            @(posedge clk); #1;
            e = sb.pop_front();
            check("b2b done", done, 1);
            check("b2b result", result, e.res);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b idle", done, 0);

        issue8("w8_mul", 5'd10, 8'hFF, 8'hFF, 8'h01, 9);
        issue8("w8_mulhu", 5'd12, 8'hFF, 8'hFF, 8'hFE, 9);
        issue8("w8_div", 5'd13, 8'hF9, 8'h02, 8'hFD, 9);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
